// File: rtl/smg_scan_decoder.sv
// -----------------------------------------------------------------------------
// smg_scan_decoder
//
// Decodes a two-digit, time-multiplexed, active-low seven-segment bus back into
// hex digit values. The bus is synchronised, and each digit phase must hold
// still for SETTLE_CYC cycles before it is latched. Each phase is latched at
// most once. Each digit carries a valid bit and a staleness timeout.
//
// Parameters
//   SETTLE_CYC   cycles a phase must hold unchanged before latching (2..255)
//   TIMEOUT_CYC  cycles without a good latch before a digit goes stale
//                (2..2^20-1)
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   sm_dat    in   [7:0] segment bus, active-low, bit7..0 = a,b,c,d,e,f,g,dp
//   sm_sel    in   [1:0] digit select, one-hot: 01 = ones, 10 = tens
//   err_clr   in   synchronous clear of pat_err
//   digit0    out  [3:0] decoded ones digit
//   digit1    out  [3:0] decoded tens digit
//   dig_vld   out  [1:0] per-digit valid
//   stale     out  [1:0] per-digit timeout flag
//   upd       out  one-cycle pulse when a digit value or valid bit changes
//   pat_err   out  sticky flag: an unrecognised pattern was latched
//   bin_val   out  [6:0] digit1*10+digit0, 127 when invalid or non-decimal
//                  (present only when SMG_BIN_OUT_EN is defined)
//
// Optional feature macro: SMG_BIN_OUT_EN
// -----------------------------------------------------------------------------
module smg_scan_decoder #(
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 200_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] sm_dat,
    input  logic [1:0] sm_sel,
    input  logic       err_clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] dig_vld,
    output logic [1:0] stale,
    output logic       upd,
    output logic       pat_err
`ifdef SMG_BIN_OUT_EN
    ,
    output logic [6:0] bin_val
`endif
);

    localparam int unsigned  NUM_DIG     = 2;
    localparam logic [7:0]   SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [19:0]  TO_LAST     = 20'(TIMEOUT_CYC - 1);
    localparam logic [19:0]  TO_SAT      = 20'(TIMEOUT_CYC);

    // Returns {ok, value}; bits are a..g, active-low.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0_0000;
        case (seg)
            7'b0000001: r = {1'b1, 4'h0};
            7'b1001111: r = {1'b1, 4'h1};
            7'b0010010: r = {1'b1, 4'h2};
            7'b0000110: r = {1'b1, 4'h3};
            7'b1001100: r = {1'b1, 4'h4};
            7'b0100100: r = {1'b1, 4'h5};
            7'b0100000: r = {1'b1, 4'h6};
            7'b0001111: r = {1'b1, 4'h7};
            7'b0000000: r = {1'b1, 4'h8};
            7'b0000100: r = {1'b1, 4'h9};
            7'b0001000: r = {1'b1, 4'hA};
            7'b1100000: r = {1'b1, 4'hB};
            7'b0110001: r = {1'b1, 4'hC};
            7'b1000010: r = {1'b1, 4'hD};
            7'b0110000: r = {1'b1, 4'hE};
            7'b0111000: r = {1'b1, 4'hF};
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Two-flop synchroniser for the asynchronous display bus
    // -------------------------------------------------------------------------
    logic [1:0] sel_s1_q, sel_s_q;
    logic [7:0] dat_s1_q, dat_s_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_s1_q <= 2'b00;
            sel_s_q  <= 2'b00;
            dat_s1_q <= 8'h00;
            dat_s_q  <= 8'h00;
        end else begin
            sel_s1_q <= sm_sel;
            sel_s_q  <= sel_s1_q;
            dat_s1_q <= sm_dat;
            dat_s_q  <= dat_s1_q;
        end
    end

    // -------------------------------------------------------------------------
    // Phase tracking FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        LATCH    = 2'd2,
        HOLD     = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] dat_q, dat_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_SEL;
            sel_q   <= 2'b00;
            dat_q   <= 8'h00;
            cnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_SEL: begin
                // 00 (blanking) and 11 (bus fight) never open a phase
                if (sel_s_q == 2'b01 || sel_s_q == 2'b10) begin
                    sel_d   = sel_s_q;
                    dat_d   = dat_s_q;
                    cnt_d   = 8'h00;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Select change aborts; data change restarts the settle window
                // (dp included, so a flickering dp also delays the latch).
                if (sel_s_q != sel_q) begin
                    state_d = WAIT_SEL;
                end else if (dat_s_q != dat_q) begin
                    dat_d = dat_s_q;
                    cnt_d = 8'h00;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LATCH: begin
                state_d = HOLD;
            end
            HOLD: begin
                if (sel_s_q != sel_q) begin
                    state_d = WAIT_SEL;
                end
            end
            default: begin
                state_d = WAIT_SEL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Digit registers, valid/stale flags and timeout counters
    // -------------------------------------------------------------------------
    logic                        latch_go;
    logic                        dec_ok;
    logic [3:0]                  dec_val;
    logic [NUM_DIG-1:0][3:0]     dig_q, dig_d;
    logic [NUM_DIG-1:0]          vld_q, vld_d;
    logic [NUM_DIG-1:0]          stale_q, stale_d;
    logic [NUM_DIG-1:0][19:0]    to_q, to_d;
    logic                        upd_q, upd_d;
    logic                        pat_err_q, pat_err_d;

    assign latch_go          = (state_q == LATCH);
    assign {dec_ok, dec_val} = seg_decode(dat_q[7:1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig_q     <= '0;
            vld_q     <= '0;
            stale_q   <= '0;
            to_q      <= '0;
            upd_q     <= 1'b0;
            pat_err_q <= 1'b0;
        end else begin
            dig_q     <= dig_d;
            vld_q     <= vld_d;
            stale_q   <= stale_d;
            to_q      <= to_d;
            upd_q     <= upd_d;
            pat_err_q <= pat_err_d;
        end
    end

    always_comb begin
        dig_d     = dig_q;
        vld_d     = vld_q;
        stale_d   = stale_q;
        to_d      = to_q;
        upd_d     = 1'b0;
        // set beats clear when both happen in the same cycle
        pat_err_d = (pat_err_q & ~err_clr) | (latch_go & ~dec_ok);
        for (int i = 0; i < NUM_DIG; i++) begin
            if (latch_go && sel_q[i] && dec_ok) begin
                // a good latch overrides a timeout landing in the same cycle
                if (!vld_q[i] || (dig_q[i] != dec_val)) begin
                    upd_d = 1'b1;
                end
                dig_d[i]   = dec_val;
                vld_d[i]   = 1'b1;
                stale_d[i] = 1'b0;
                to_d[i]    = 20'd0;
            end else if (to_q[i] == TO_LAST) begin
                // counter reaches TIMEOUT_CYC this edge and then saturates,
                // so the stale event (and its upd pulse) fires only once
                to_d[i]    = TO_SAT;
                stale_d[i] = 1'b1;
                vld_d[i]   = 1'b0;
                upd_d      = 1'b1;
            end else if (to_q[i] != TO_SAT) begin
                to_d[i] = to_q[i] + 20'd1;
            end
        end
    end

    assign digit0  = dig_q[0];
    assign digit1  = dig_q[1];
    assign dig_vld = vld_q;
    assign stale   = stale_q;
    assign upd     = upd_q;
    assign pat_err = pat_err_q;

`ifdef SMG_BIN_OUT_EN
    // -------------------------------------------------------------------------
    // Binary value, computed from next-state digits so it moves with upd
    // -------------------------------------------------------------------------
    logic [6:0] bin_q, bin_d;

    always_comb begin
        bin_d = 7'd127;
        if (vld_d == 2'b11 && dig_d[0] <= 4'd9 && dig_d[1] <= 4'd9) begin
            bin_d = ({3'b000, dig_d[1]} * 7'd10) + {3'b000, dig_d[0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q <= 7'd127;
        end else begin
            bin_q <= bin_d;
        end
    end

    assign bin_val = bin_q;
`endif

endmodule
